// File: rtl/issue_steer_queue_pkg.sv
// Shared definitions for the dual-issue steering front end: RISC-V opcode
// constants, the canonical NOP, the slot-class enum and the pair hazard rule.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Which decoder slot(s) an instruction may occupy.
  typedef enum logic [1:0] {
    CLS_ANY   = 2'd0,
    CLS_AONLY = 2'd1,
    CLS_BONLY = 2'd2
  } issue_class_e;

  // Which queue head entry feeds a slot.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_I0   = 2'd1,
    SRC_I1   = 2'd2
  } slot_src_e;

  // RAW or WAW between the two head entries. i0_wr already excludes x0.
  function automatic logic pair_hazard(
    input logic       i0_wr,
    input logic [4:0] i0_rd,
    input logic       i1_r1,
    input logic [4:0] i1_rs1,
    input logic       i1_r2,
    input logic [4:0] i1_rs2,
    input logic       i1_wr,
    input logic [4:0] i1_rd
  );
    return i0_wr && ((i1_r1 && (i1_rs1 == i0_rd)) ||
                     (i1_r2 && (i1_rs2 == i0_rd)) ||
                     (i1_wr && (i1_rd  == i0_rd)));
  endfunction

endpackage

// File: rtl/issue_steer_queue_classifier.sv
// Combinational decode of one instruction into its slot class and the
// register fields the hazard check needs.
module issue_classifier
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_inst,
  output issue_class_e    o_cls,
  output logic [4:0]      o_rd,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic            o_writes_rd,
  output logic            o_reads_rs1,
  output logic            o_reads_rs2
);

  logic [6:0] w_opcode;
  logic       w_wr_type;
  logic       w_unused_bits;

  assign w_opcode = i_inst[6:0];
  assign o_rd     = i_inst[11:7];
  assign o_rs1    = i_inst[19:15];
  assign o_rs2    = i_inst[24:20];

  // funct3/funct7 do not influence steering.
  assign w_unused_bits = ^{i_inst[XLEN-1:25], i_inst[14:12]};

  // Opcode -> class and register usage; unknown opcodes are ANY with no regs.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path through
    // this block can leave a value unassigned and infer a latch.
    o_cls       = CLS_ANY;
    w_wr_type   = 1'b0;
    o_reads_rs1 = 1'b0;
    o_reads_rs2 = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_wr_type   = 1'b1;
        o_reads_rs1 = 1'b1;
        o_reads_rs2 = 1'b1;
      end
      OP_I: begin
        w_wr_type   = 1'b1;
        o_reads_rs1 = 1'b1;
      end
      OP_LOAD: begin
        o_cls       = CLS_BONLY;
        w_wr_type   = 1'b1;
        o_reads_rs1 = 1'b1;
      end
      OP_STORE: begin
        o_cls       = CLS_BONLY;
        o_reads_rs1 = 1'b1;
        o_reads_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        o_cls       = CLS_AONLY;
        o_reads_rs1 = 1'b1;
        o_reads_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  // Writes to x0 are architecturally discarded and never create a hazard.
  assign o_writes_rd = w_wr_type && (o_rd != 5'd0);

endmodule

// File: rtl/issue_steer_queue.sv
// Dual-issue front end: an in-order instruction queue fed in pairs by fetch,
// with steering of the two oldest entries into registered decoder slots A
// (ALU/branch) and B (ALU/load/store).
module issue_steer_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            fetch_valid,
  input  logic [XLEN-1:0] fetch_inst0,
  input  logic [XLEN-1:0] fetch_inst1,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            fetch_ready,
  input  logic            issue_ready,
  output logic            slot_a_valid,
  output logic [XLEN-1:0] slot_a_inst,
  output logic [XLEN-1:0] slot_a_pc,
  output logic            slot_b_valid,
  output logic [XLEN-1:0] slot_b_inst,
  output logic [XLEN-1:0] slot_b_pc,
  output logic [15:0]     single_issue_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [XLEN-1:0] NOP_X = XLEN'(NOP);

  // Queue storage and bookkeeping
  logic [XLEN-1:0] r_mem_inst [DEPTH];
  logic [XLEN-1:0] r_mem_pc   [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  // Slot registers and counter
  logic            r_a_valid;
  logic [XLEN-1:0] r_a_inst;
  logic [XLEN-1:0] r_a_pc;
  logic            r_b_valid;
  logic [XLEN-1:0] r_b_inst;
  logic [XLEN-1:0] r_b_pc;
  logic [15:0]     r_single_cnt;

  // Combinational
  logic            w_push;
  logic            w_load;
  logic [1:0]      w_pop;
  logic [1:0]      w_n_issue;
  logic [PW-1:0]   w_wr_ptr1;
  logic [PW-1:0]   w_rd_ptr1;
  logic [CW-1:0]   w_count_nxt;
  logic            w_v0;
  logic            w_v1;
  logic [XLEN-1:0] w_i0_inst;
  logic [XLEN-1:0] w_i0_pc;
  logic [XLEN-1:0] w_i1_inst;
  logic [XLEN-1:0] w_i1_pc;
  issue_class_e    w_i0_cls;
  issue_class_e    w_i1_cls;
  logic [4:0]      w_i0_rd;
  logic [4:0]      w_i0_rs1;
  logic [4:0]      w_i0_rs2;
  logic            w_i0_wr;
  logic            w_i0_r1;
  logic            w_i0_r2;
  logic [4:0]      w_i1_rd;
  logic [4:0]      w_i1_rs1;
  logic [4:0]      w_i1_rs2;
  logic            w_i1_wr;
  logic            w_i1_r1;
  logic            w_i1_r2;
  logic            w_hazard;
  logic            w_pair_ok;
  logic            w_single;
  logic            w_unused_i0;
  slot_src_e       w_a_src;
  slot_src_e       w_b_src;
  logic [XLEN-1:0] w_a_inst_nxt;
  logic [XLEN-1:0] w_a_pc_nxt;
  logic [XLEN-1:0] w_b_inst_nxt;
  logic [XLEN-1:0] w_b_pc_nxt;

  // Fetch handshake: judged on the current occupancy only, no pop credit.
  assign fetch_ready = (r_count <= CW'(DEPTH - 2));
  assign w_push      = fetch_valid && fetch_ready && !flush;

  assign w_wr_ptr1 = r_wr_ptr + PW'(1);
  assign w_rd_ptr1 = r_rd_ptr + PW'(1);

  // Pair write into the queue; inst1 sits at the next sequential PC.
  // NOTE: the storage array has no reset; an entry is only read once the
  // count says it was written, so clearing it would add reset fan-out for
  // no behavioural gain.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_inst[r_wr_ptr]  <= fetch_inst0;
      r_mem_pc[r_wr_ptr]    <= fetch_pc;
      r_mem_inst[w_wr_ptr1] <= fetch_inst1;
      r_mem_pc[w_wr_ptr1]   <= fetch_pc + XLEN'(4);
    end
  end

  // Two oldest entries
  assign w_v0      = (r_count != '0);
  assign w_v1      = (r_count >= CW'(2));
  assign w_i0_inst = r_mem_inst[r_rd_ptr];
  assign w_i0_pc   = r_mem_pc[r_rd_ptr];
  assign w_i1_inst = r_mem_inst[w_rd_ptr1];
  assign w_i1_pc   = r_mem_pc[w_rd_ptr1];

  issue_classifier #(.XLEN(XLEN)) u_cls_i0 (
    .i_inst      (w_i0_inst),
    .o_cls       (w_i0_cls),
    .o_rd        (w_i0_rd),
    .o_rs1       (w_i0_rs1),
    .o_rs2       (w_i0_rs2),
    .o_writes_rd (w_i0_wr),
    .o_reads_rs1 (w_i0_r1),
    .o_reads_rs2 (w_i0_r2)
  );

  issue_classifier #(.XLEN(XLEN)) u_cls_i1 (
    .i_inst      (w_i1_inst),
    .o_cls       (w_i1_cls),
    .o_rd        (w_i1_rd),
    .o_rs1       (w_i1_rs1),
    .o_rs2       (w_i1_rs2),
    .o_writes_rd (w_i1_wr),
    .o_reads_rs1 (w_i1_r1),
    .o_reads_rs2 (w_i1_r2)
  );

  // Source operands of the older entry never matter for pairing.
  assign w_unused_i0 = ^{w_i0_rs1, w_i0_rs2, w_i0_r1, w_i0_r2};

  assign w_hazard  = pair_hazard(w_i0_wr, w_i0_rd, w_i1_r1, w_i1_rs1,
                                 w_i1_r2, w_i1_rs2, w_i1_wr, w_i1_rd);
  assign w_pair_ok = w_v1 && !w_hazard;

  // Steering: choose which head entry feeds each slot and how many issue.
  always_comb begin
    w_a_src   = SRC_NONE;
    w_b_src   = SRC_NONE;
    w_n_issue = 2'd0;
    if (w_v0) begin
      case (w_i0_cls)
        CLS_AONLY: begin
          // Nothing pairs behind a branch.
          w_a_src   = SRC_I0;
          w_n_issue = 2'd1;
        end
        CLS_BONLY: begin
          w_b_src   = SRC_I0;
          w_n_issue = 2'd1;
          if (w_pair_ok && (w_i1_cls != CLS_BONLY)) begin
            w_a_src   = SRC_I1;
            w_n_issue = 2'd2;
          end
        end
        default: begin
          if (!w_pair_ok) begin
            w_a_src   = SRC_I0;
            w_n_issue = 2'd1;
          end else if (w_i1_cls == CLS_AONLY) begin
            w_a_src   = SRC_I1;
            w_b_src   = SRC_I0;
            w_n_issue = 2'd2;
          end else begin
            w_a_src   = SRC_I0;
            w_b_src   = SRC_I1;
            w_n_issue = 2'd2;
          end
        end
      endcase
    end
  end

  // Slot payloads for the steering result; empty slots carry NOP at PC 0.
  always_comb begin
    w_a_inst_nxt = NOP_X;
    w_a_pc_nxt   = '0;
    w_b_inst_nxt = NOP_X;
    w_b_pc_nxt   = '0;
    case (w_a_src)
      SRC_I0:  begin w_a_inst_nxt = w_i0_inst; w_a_pc_nxt = w_i0_pc; end
      SRC_I1:  begin w_a_inst_nxt = w_i1_inst; w_a_pc_nxt = w_i1_pc; end
      default: ;
    endcase
    case (w_b_src)
      SRC_I0:  begin w_b_inst_nxt = w_i0_inst; w_b_pc_nxt = w_i0_pc; end
      SRC_I1:  begin w_b_inst_nxt = w_i1_inst; w_b_pc_nxt = w_i1_pc; end
      default: ;
    endcase
  end

  // Slots reload when empty or when both decoders take them this cycle.
  assign w_load      = !(r_a_valid || r_b_valid) || issue_ready;
  assign w_pop       = (w_load && !flush) ? w_n_issue : 2'd0;
  assign w_count_nxt = r_count + (w_push ? CW'(2) : CW'(0)) - CW'(w_pop);
  assign w_single    = (w_a_src != SRC_NONE) ^ (w_b_src != SRC_NONE);

  // Queue pointers and occupancy; flush empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers use non-blocking assignment so every flop samples the
    // pre-edge values regardless of statement order across blocks.
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(2);
      r_rd_ptr <= r_rd_ptr + PW'(w_pop);
      r_count  <= w_count_nxt;
    end
  end

  // Slot registers: cleared by flush, reloaded on load, otherwise held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_valid <= 1'b0;
      r_a_inst  <= NOP_X;
      r_a_pc    <= '0;
      r_b_valid <= 1'b0;
      r_b_inst  <= NOP_X;
      r_b_pc    <= '0;
    end else if (flush) begin
      r_a_valid <= 1'b0;
      r_a_inst  <= NOP_X;
      r_a_pc    <= '0;
      r_b_valid <= 1'b0;
      r_b_inst  <= NOP_X;
      r_b_pc    <= '0;
    end else if (w_load) begin
      r_a_valid <= (w_a_src != SRC_NONE);
      r_a_inst  <= w_a_inst_nxt;
      r_a_pc    <= w_a_pc_nxt;
      r_b_valid <= (w_b_src != SRC_NONE);
      r_b_inst  <= w_b_inst_nxt;
      r_b_pc    <= w_b_pc_nxt;
    end
  end

  // Saturating count of loads that filled exactly one slot; flush keeps it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_single_cnt <= '0;
    end else if (!flush && w_load && w_single && (r_single_cnt != 16'hFFFF)) begin
      r_single_cnt <= r_single_cnt + 16'd1;
    end
  end

  assign slot_a_valid     = r_a_valid;
  assign slot_a_inst      = r_a_inst;
  assign slot_a_pc        = r_a_pc;
  assign slot_b_valid     = r_b_valid;
  assign slot_b_inst      = r_b_inst;
  assign slot_b_pc        = r_b_pc;
  assign single_issue_cnt = r_single_cnt;

endmodule

// File: tb/tb_issue_steer_queue.sv
// Self-checking bench for issue_steer_queue: a directed vector table, hand
// sequences for back-pressure, flush and async reset, then random traffic
// against a queue-based reference model.
module tb_issue_steer_queue;

  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam logic [31:0] NOPI = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        fetch_valid;
  logic [31:0] fetch_inst0;
  logic [31:0] fetch_inst1;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic        issue_ready;
  logic        slot_a_valid;
  logic [31:0] slot_a_inst;
  logic [31:0] slot_a_pc;
  logic        slot_b_valid;
  logic [31:0] slot_b_inst;
  logic [31:0] slot_b_pc;
  logic [15:0] single_issue_cnt;

  issue_steer_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .fetch_valid      (fetch_valid),
    .fetch_inst0      (fetch_inst0),
    .fetch_inst1      (fetch_inst1),
    .fetch_pc         (fetch_pc),
    .fetch_ready      (fetch_ready),
    .issue_ready      (issue_ready),
    .slot_a_valid     (slot_a_valid),
    .slot_a_inst      (slot_a_inst),
    .slot_a_pc        (slot_a_pc),
    .slot_b_valid     (slot_b_valid),
    .slot_b_inst      (slot_b_inst),
    .slot_b_pc        (slot_b_pc),
    .single_issue_cnt (single_issue_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  entry_t      mq[$];
  logic        ma_v, mb_v;
  logic [31:0] ma_i, ma_pc, mb_i, mb_pc;
  int          m_cnt;

  // 0 = either slot, 1 = slot A only, 2 = slot B only
  function automatic int kind(input logic [31:0] x);
    if (x[6:0] == 7'b1100011) return 1;
    if (x[6:0] == 7'b0000011 || x[6:0] == 7'b0100011) return 2;
    return 0;
  endfunction

  function automatic bit dependent(input logic [31:0] older, input logic [31:0] younger);
    logic [6:0] op0, op1;
    logic [4:0] d;
    bit rs1_used, rs2_used, wr1;
    op0 = older[6:0];
    op1 = younger[6:0];
    d   = older[11:7];
    if (!(op0 == 7'b0110011 || op0 == 7'b0010011 || op0 == 7'b0000011) || d == 5'd0) return 0;
    rs1_used = op1 inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
    rs2_used = op1 inside {7'b0110011, 7'b0100011, 7'b1100011};
    wr1      = op1 inside {7'b0110011, 7'b0010011, 7'b0000011};
    return (rs1_used && younger[19:15] == d) || (rs2_used && younger[24:20] == d) ||
           (wr1 && younger[11:7] == d);
  endfunction

  task automatic model_reset();
    mq.delete();
    ma_v = 0; ma_i = NOPI; ma_pc = 0;
    mb_v = 0; mb_i = NOPI; mb_pc = 0;
    m_cnt = 0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    bit ready;
    int take, k0, k1;
    bit pairable;
    ready = (mq.size() <= DEPTH - 2);
    if (flush) begin
      mq.delete();
      ma_v = 0; ma_i = NOPI; ma_pc = 0;
      mb_v = 0; mb_i = NOPI; mb_pc = 0;
      return;
    end
    if (!(ma_v || mb_v) || issue_ready) begin
      ma_v = 0; ma_i = NOPI; ma_pc = 0;
      mb_v = 0; mb_i = NOPI; mb_pc = 0;
      take = 0;
      if (mq.size() >= 1) begin
        k0 = kind(mq[0].inst);
        pairable = 0;
        if (mq.size() >= 2) begin
          k1 = kind(mq[1].inst);
          pairable = (k0 != 1) && !(k0 == 2 && k1 == 2) && !dependent(mq[0].inst, mq[1].inst);
        end
        if (!pairable) begin
          take = 1;
          if (k0 == 2) begin mb_v = 1; mb_i = mq[0].inst; mb_pc = mq[0].pc; end
          else         begin ma_v = 1; ma_i = mq[0].inst; ma_pc = mq[0].pc; end
        end else begin
          take = 2;
          if (k0 == 2 || k1 == 1) begin
            ma_v = 1; ma_i = mq[1].inst; ma_pc = mq[1].pc;
            mb_v = 1; mb_i = mq[0].inst; mb_pc = mq[0].pc;
          end else begin
            ma_v = 1; ma_i = mq[0].inst; ma_pc = mq[0].pc;
            mb_v = 1; mb_i = mq[1].inst; mb_pc = mq[1].pc;
          end
        end
      end
      if (take == 1 && m_cnt < 65535) m_cnt++;
      repeat (take) void'(mq.pop_front());
    end
    if (fetch_valid && ready) begin
      mq.push_back('{inst: fetch_inst0, pc: fetch_pc});
      mq.push_back('{inst: fetch_inst1, pc: fetch_pc + 32'd4});
    end
  endtask

  function automatic logic [146:0] ev(input bit av, input logic [31:0] ai, input logic [31:0] ap,
                                      input bit bv, input logic [31:0] bi, input logic [31:0] bp,
                                      input int cnt, input bit fr);
    return {av, ai, ap, bv, bi, bp, 16'(cnt), fr};
  endfunction

  function automatic logic [146:0] dut_vec();
    return {slot_a_valid, slot_a_inst, slot_a_pc, slot_b_valid, slot_b_inst, slot_b_pc,
            single_issue_cnt, fetch_ready};
  endfunction

  function automatic logic [146:0] model_vec();
    return ev(ma_v, ma_i, ma_pc, mb_v, mb_i, mb_pc, m_cnt, mq.size() <= DEPTH - 2);
  endfunction

  task automatic tick(input string name);
    @(posedge clk);
    model_step();
    #1;
    check(name, dut_vec(), model_vec());
  endtask

  function automatic logic [31:0] addi_k(input int k);
    return {12'(k), 5'd0, 3'd0, 5'(k), 7'b0010011};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0] op;
    case ($urandom_range(0, 5))
      0: op = 7'b0110011;
      1: op = 7'b0010011;
      2: op = 7'b0000011;
      3: op = 7'b0100011;
      4: op = 7'b1100011;
      default: op = 7'b1101111;
    endcase
    return {7'd0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'd0,
            5'($urandom_range(0, 3)), op};
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         fv;
    logic [31:0]  i0;
    logic [31:0]  i1;
    logic [31:0]  pc;
    logic [146:0] exp;
  } vec_t;

  vec_t tbl[11];

  localparam logic [31:0] ADD  = 32'h003100B3; // add  x1,x2,x3
  localparam logic [31:0] LW5  = 32'h00032283; // lw   x5,0(x6)
  localparam logic [31:0] LW6  = 32'h00432303; // lw   x6,4(x6)
  localparam logic [31:0] BEQ  = 32'h00208463; // beq  x1,x2,+8
  localparam logic [31:0] ADDI = 32'h00108213; // addi x4,x1,1

  initial begin
    int got[$];
    bit saw_stall;

    tbl[0]  = '{1, ADD,  LW5,  32'h100, ev(0, NOPI, 0, 0, NOPI, 0, 0, 1)};
    tbl[1]  = '{0, 0,    0,    0,       ev(1, ADD, 32'h100, 1, LW5, 32'h104, 0, 1)};
    tbl[2]  = '{1, BEQ,  ADD,  32'h200, ev(0, NOPI, 0, 0, NOPI, 0, 0, 1)};
    tbl[3]  = '{1, LW5,  LW6,  32'h300, ev(1, BEQ, 32'h200, 0, NOPI, 0, 1, 1)};
    tbl[4]  = '{0, 0,    0,    0,       ev(1, ADD, 32'h204, 1, LW5, 32'h300, 1, 1)};
    tbl[5]  = '{1, ADD,  ADDI, 32'h400, ev(0, NOPI, 0, 1, LW6, 32'h304, 2, 1)};
    tbl[6]  = '{0, 0,    0,    0,       ev(1, ADD, 32'h400, 0, NOPI, 0, 3, 1)};
    tbl[7]  = '{1, LW5,  LW6,  32'h500, ev(1, ADDI, 32'h404, 0, NOPI, 0, 4, 1)};
    tbl[8]  = '{0, 0,    0,    0,       ev(0, NOPI, 0, 1, LW5, 32'h500, 5, 1)};
    tbl[9]  = '{0, 0,    0,    0,       ev(0, NOPI, 0, 1, LW6, 32'h504, 6, 1)};
    tbl[10] = '{0, 0,    0,    0,       ev(0, NOPI, 0, 0, NOPI, 0, 6, 1)};

    rst_n = 0; flush = 0; fetch_valid = 0; issue_ready = 1;
    fetch_inst0 = 0; fetch_inst1 = 0; fetch_pc = 0;
    model_reset();
    #12;
    check("reset", dut_vec(), ev(0, NOPI, 0, 0, NOPI, 0, 0, 1));
    @(negedge clk);
    rst_n = 1;

    for (int r = 0; r < 11; r++) begin
      fetch_valid = tbl[r].fv; fetch_inst0 = tbl[r].i0;
      fetch_inst1 = tbl[r].i1; fetch_pc = tbl[r].pc;
      @(posedge clk);
      model_step();
      #1;
      check($sformatf("table row %0d", r), dut_vec(), tbl[r].exp);
    end

    // Back-pressure: stall decoders, keep offering pairs.
    issue_ready = 0;
    saw_stall = 0;
    for (int j = 0; j < 8; j++) begin
      fetch_valid = 1;
      if (j < 5) begin
        fetch_inst0 = addi_k(2 * j + 1); fetch_inst1 = addi_k(2 * j + 2);
      end else begin
        fetch_inst0 = addi_k(30); fetch_inst1 = addi_k(31);
      end
      fetch_pc = 32'h1000 + 32'(8 * j);
      tick("backpressure");
      if (!fetch_ready) saw_stall = 1;
    end
    check("stall fetch_ready low", {159'd0, fetch_ready}, 160'd0);
    check("stall observed", {159'd0, saw_stall}, 160'd1);
    fetch_valid = 0; issue_ready = 1;
    for (int c = 0; c < 12; c++) begin
      if (slot_a_valid) got.push_back(int'(slot_a_inst[11:7]));
      if (slot_b_valid) got.push_back(int'(slot_b_inst[11:7]));
      tick("drain");
    end
    check("drain length", 160'(got.size()), 160'd10);
    for (int k = 0; k < got.size() && k < 10; k++)
      check($sformatf("drain order %0d", k), 160'(got[k]), 160'(k + 1));

    // Flush with a full queue and a pair on offer.
    issue_ready = 0;
    for (int j = 0; j < 5; j++) begin
      fetch_valid = 1; fetch_inst0 = ADD; fetch_inst1 = LW5;
      fetch_pc = 32'h2000 + 32'(8 * j);
      tick("fill");
    end
    check("full fetch_ready", {159'd0, fetch_ready}, 160'd0);
    flush = 1;
    tick("flush");
    check("flush slot_a_valid", {159'd0, slot_a_valid}, 160'd0);
    check("flush fetch_ready", {159'd0, fetch_ready}, 160'd1);
    check("flush keeps counter", 160'(single_issue_cnt), 160'd6);
    flush = 0; fetch_valid = 0; issue_ready = 1;
    tick("post flush");
    check("post flush empty", {158'd0, slot_a_valid, slot_b_valid}, 160'd0);

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      flush       = ($urandom_range(0, 99) < 3);
      fetch_valid = ($urandom_range(0, 99) < 70);
      issue_ready = ($urandom_range(0, 99) < 60);
      fetch_inst0 = rand_inst();
      fetch_inst1 = rand_inst();
      fetch_pc    = 32'($urandom_range(0, 1023)) << 3;
      tick("random");
    end

    // Asynchronous reset between clock edges, mid-burst.
    flush = 0; fetch_valid = 1; issue_ready = 0;
    fetch_inst0 = ADD; fetch_inst1 = LW5; fetch_pc = 32'h3000;
    tick("pre reset");
    tick("pre reset");
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check("async reset", dut_vec(), ev(0, NOPI, 0, 0, NOPI, 0, 0, 1));
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 40; c++) begin
      fetch_valid = ($urandom_range(0, 99) < 70);
      issue_ready = ($urandom_range(0, 99) < 70);
      fetch_inst0 = rand_inst();
      fetch_inst1 = rand_inst();
      fetch_pc    = 32'($urandom_range(0, 1023)) << 3;
      tick("after reset");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
